// File: rtl/demo_sel_ctrl.sv
// demo_sel_ctrl
//   Turns the two raw board keys into the VGA pattern generator's demo index.
//   Keys are synchronised and debounced. A press steps the index up or down, with
//   wrap or saturate at the bounds. Holding a single key auto-repeats, paced by
//   frame ticks. Pressing both keys (a chord) returns the index to 0.
//   Optional autoplay is enabled by defining DEMO_AUTOPLAY_EN: while the keys are
//   idle it steps the index up every AUTO_FRAMES frame ticks.
// Ports
//   clk            system clock
//   rst            asynchronous reset, active-high
//   i_key_up_n     raw up key, active-low, asynchronous
//   i_key_dn_n     raw down key, active-low, asynchronous
//   i_frame_tick   one-cycle pulse per video frame
//   o_sel_demo     current demo index
//   o_sel_change   pulse in the cycle after o_sel_demo takes a new value
//   o_keys         committed key levels {dn,up}, 1 = pressed
//   o_auto_active  autoplay currently has control
module demo_sel_ctrl #(
   parameter int unsigned DB_CYCLES    = 240000,
   parameter int unsigned N_DEMOS      = 16,
   parameter int unsigned SEL_W        = 4,
   parameter int unsigned WRAP         = 1,
   parameter int unsigned REPEAT_DELAY = 30,
   parameter int unsigned REPEAT_RATE  = 6,
   parameter int unsigned AUTO_FRAMES  = 300
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_key_up_n,
   input  logic             i_key_dn_n,
   input  logic             i_frame_tick,
   output logic [SEL_W-1:0] o_sel_demo,
   output logic             o_sel_change,
   output logic [1:0]       o_keys,
   output logic             o_auto_active
);

   localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   // One width serves every frame-tick counter (repeat and autoplay idle)
   localparam int unsigned FRM_MAX = (REP_MAX > AUTO_FRAMES) ? REP_MAX : AUTO_FRAMES;
   localparam int unsigned FRM_W   = $clog2(FRM_MAX + 1);

   localparam logic [SEL_W-1:0] SEL_MAX    = SEL_W'(N_DEMOS - 1);
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
   localparam logic [FRM_W-1:0] DELAY_LAST = FRM_W'(REPEAT_DELAY - 1);
   localparam logic [FRM_W-1:0] RATE_LAST  = FRM_W'(REPEAT_RATE - 1);
   localparam logic             WRAP_EN    = (WRAP != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_REPEAT,
      S_CHORD
   } state_t;

   logic [1:0]       sync_q1, sync_q2;
   logic [DB_W-1:0]  db_cnt [2];
   logic [1:0]       keys_prev;
   logic [1:0]       rise;
   logic             chord_ev, press_ev;
   state_t           state, state_nxt;
   logic [FRM_W-1:0] rep_cnt, rep_cnt_nxt;
   logic             step_req, chord_clr, auto_step;
   logic [SEL_W-1:0] sel_nxt;

   function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s, input logic wrap);
      if (s == SEL_MAX) return wrap ? '0 : SEL_MAX;
      return s + SEL_W'(1);
   endfunction

   function automatic logic [SEL_W-1:0] sel_dec(input logic [SEL_W-1:0] s, input logic wrap);
      if (s == '0) return wrap ? SEL_MAX : '0;
      return s - SEL_W'(1);
   endfunction

   // Two-flop synchroniser, stored as pressed = 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= ~{i_key_dn_n, i_key_up_n};
         sync_q2 <= sync_q1;
      end
   end

   // Debounce: commit after DB_CYCLES consecutive cycles at the new level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
         o_keys    <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_q2[i] == o_keys[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               o_keys[i] <= sync_q2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Key events seen in the cycle after a commit
   assign rise     = o_keys & ~keys_prev;
   assign chord_ev = (o_keys == 2'b11) && (keys_prev != 2'b11);
   assign press_ev = ((o_keys == 2'b01) || (o_keys == 2'b10)) && (rise == o_keys);

   // Press / repeat / chord control
   always_comb begin
      state_nxt   = state;
      rep_cnt_nxt = rep_cnt;
      step_req    = 1'b0;
      chord_clr   = 1'b0;
      if (chord_ev) begin
         state_nxt   = S_CHORD;
         rep_cnt_nxt = '0;
         chord_clr   = 1'b1;
      end else if (press_ev) begin
         // A press wins over a coincident frame tick
         state_nxt   = S_DELAY;
         rep_cnt_nxt = '0;
         step_req    = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
            end
            S_DELAY, S_REPEAT: begin
               if ((o_keys != 2'b01) && (o_keys != 2'b10)) begin
                  state_nxt   = (o_keys == 2'b00) ? S_IDLE : S_CHORD;
                  rep_cnt_nxt = '0;
               end else if (i_frame_tick) begin
                  if (rep_cnt == ((state == S_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                     state_nxt   = S_REPEAT;
                     rep_cnt_nxt = '0;
                     step_req    = 1'b1;
                  end else begin
                     rep_cnt_nxt = rep_cnt + FRM_W'(1);
                  end
               end
            end
            S_CHORD: begin
               // Stay locked out until both keys are released or a fresh press arrives
               if (o_keys == 2'b00) state_nxt = S_IDLE;
            end
            default: begin
               state_nxt   = S_IDLE;
               rep_cnt_nxt = '0;
            end
         endcase
      end
   end

`ifdef DEMO_AUTOPLAY_EN
   localparam logic [FRM_W-1:0] AUTO_LAST = FRM_W'(AUTO_FRAMES - 1);

   logic [FRM_W-1:0] idle_cnt, idle_cnt_nxt;
   logic             auto_nxt;
   logic             key_chg;

   assign key_chg = (o_keys != keys_prev);

   // Idle frame counter; any committed key change hands control back to the user
   always_comb begin
      idle_cnt_nxt = idle_cnt;
      auto_nxt     = o_auto_active;
      auto_step    = 1'b0;
      if (key_chg) begin
         idle_cnt_nxt = '0;
         auto_nxt     = 1'b0;
      end else if ((o_keys == 2'b00) && i_frame_tick) begin
         if (idle_cnt == AUTO_LAST) begin
            idle_cnt_nxt = '0;
            auto_nxt     = 1'b1;
            auto_step    = 1'b1;
         end else begin
            idle_cnt_nxt = idle_cnt + FRM_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt      <= '0;
         o_auto_active <= 1'b0;
      end else begin
         idle_cnt      <= idle_cnt_nxt;
         o_auto_active <= auto_nxt;
      end
   end
`else
   assign auto_step     = 1'b0;
   assign o_auto_active = 1'b0;
`endif

   // Next index; autoplay always wraps regardless of WRAP
   always_comb begin
      sel_nxt = o_sel_demo;
      if (chord_clr) begin
         sel_nxt = '0;
      end else if (step_req) begin
         sel_nxt = o_keys[0] ? sel_inc(o_sel_demo, WRAP_EN) : sel_dec(o_sel_demo, WRAP_EN);
      end else if (auto_step) begin
         sel_nxt = sel_inc(o_sel_demo, 1'b1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         rep_cnt      <= '0;
         keys_prev    <= '0;
         o_sel_demo   <= '0;
         o_sel_change <= 1'b0;
      end else begin
         state        <= state_nxt;
         rep_cnt      <= rep_cnt_nxt;
         keys_prev    <= o_keys;
         o_sel_demo   <= sel_nxt;
         o_sel_change <= (sel_nxt != o_sel_demo);
      end
   end

endmodule
